// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one fixed-latency ALU among requesters
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [DATA_W-1:0]         alu_op,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant;
  logic             grant_vld;
  logic [LAT_W-1:0] lat_cnt;

  // Walk offsets from the far end back toward rr_ptr so the nearest valid requester wins.
  always_comb begin
    grant     = rr_ptr;
    grant_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant     = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lat_cnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            alu_a   <= req_a[int'(grant)*DATA_W +: DATA_W];
            alu_b   <= req_b[int'(grant)*DATA_W +: DATA_W];
            alu_op  <= req_op[int'(grant)*DATA_W +: DATA_W];
            owner   <= grant;
            rr_ptr  <= IDX_W'((int'(grant) + 1) % NUM_REQ);
            lat_cnt <= LAT_W'(ALU_LAT - 1);
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (lat_cnt == '0) begin
            rsp_result <= alu_result;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with transaction-level reference model
module tb_alu_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*32-1:0] req_a = '0, req_b = '0, req_op = '0;
  logic [31:0]   alu_a, alu_b, alu_op, alu_result, rsp_result;
  logic          busy;

  logic [1:0]    req_valid3 = '0, req_ready3, rsp_valid3, rsp_ready3 = '0;
  logic [63:0]   req_a3 = '0, req_b3 = '0, req_op3 = '0;
  logic [31:0]   alu_a3, alu_b3, alu_op3, alu_result3, rsp_result3;
  logic          busy3;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [31:0] op);
    case (op)
      32'd0:   return a + b;
      32'd1:   return a - b;
      32'd2:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_a, alu_b, alu_op);
  assign alu_result3 = alu_f(alu_a3, alu_b3, alu_op3);

  alu_arbiter #(.NUM_REQ(N), .DATA_W(32), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy));

  alu_arbiter #(.NUM_REQ(2), .DATA_W(32), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .busy(busy3));

  int errors = 0;
  int checks = 0;

  // Requester-side state and transaction-level model of the shared ALU.
  logic [N-1:0] pend = '0;
  logic [31:0]  ra[N], rb[N], rop[N];
  bit           m_busy = 0;
  int           m_owner = 0, m_ptr = 0, m_due = 0, cyc = 0;
  logic [31:0]  m_a = '0, m_b = '0, m_op = '0, m_res = '0;
  int           gen_rate = 0, rdy_rate = 100;
  bit           rr_mode = 0;
  int           act_grants[$];
  logic [31:0]  rsp_log[$];

  typedef struct {
    int          idx;
    logic [31:0] a, b, op, res;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32]  = ra[i];
      req_b[i*32 +: 32]  = rb[i];
      req_op[i*32 +: 32] = rop[i];
    end
  endtask

  task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic [31:0] op);
    ra[i] = a; rb[i] = b; rop[i] = op; pend[i] = 1'b1;
    drive();
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: check outputs at negedge, choose handshakes, then update inputs after the posedge.
  task automatic step();
    bit            resp, acc;
    int            g;
    logic [N-1:0]  exp_rr, exp_rv;
    @(negedge clk);
    resp   = m_busy && (cyc >= m_due);
    g      = m_busy ? -1 : pick();
    exp_rr = (g >= 0) ? (N'(1) << g) : '0;
    exp_rv = resp ? (N'(1) << m_owner) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    if (resp) chk("rsp_result", rsp_result, m_res);
    for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(99) < rdy_rate);
    acc = (g >= 0);
    if (acc) begin
      act_grants.push_back(onehot_idx(req_ready));
      m_busy = 1; m_owner = g; m_ptr = (g + 1) % N;
      m_a = ra[g]; m_b = rb[g]; m_op = rop[g];
      m_res = alu_f(ra[g], rb[g], rop[g]);
      m_due = cyc + 1 + LAT;
    end else if (resp && rsp_ready[m_owner]) begin
      m_busy = 0;
      rsp_log.push_back(rsp_result);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (acc) pend[g] = 1'b0;
    if (gen_rate > 0)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(99) < gen_rate) begin
          if (rr_mode) begin
            ra[i] = i; rb[i] = i; rop[i] = 0;
          end else begin
            ra[i] = $urandom; rb[i] = $urandom;
            rop[i] = $urandom_range(1) ? 32'($urandom_range(3)) : $urandom;
          end
          pend[i] = 1'b1;
        end
    drive();
  endtask

  task automatic run_until_idle(int bound);
    for (int n = 0; n < bound; n++) begin
      step();
      if (!m_busy && pend == '0) return;
    end
    checks++; errors++;
    $display("FAIL drain: still busy=%0d pend=%b after %0d cycles, expected idle", m_busy, pend, bound);
  endtask

  task automatic do_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, alu_op, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0; m_op = '0;
    rsp_ready = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[5];
    int   exp_order[5];
    vecs[0] = '{0, 32'd10, 32'd5, 32'd2, 32'd0};
    vecs[1] = '{0, 32'd15, 32'd10, 32'd1, 32'd5};
    vecs[2] = '{3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    vecs[3] = '{2, 32'h0000_F0F0, 32'h0000_0FF0, 32'd2, 32'h0000_00F0};
    vecs[4] = '{1, 32'd3, 32'd5, 32'd1, 32'hFFFF_FFFE};
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = '0; end

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", alu_op, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU_LAT=3 instance: ADD wraps to 0, result appears exactly three edges after accept.
    req_valid3 = 2'b01; req_a3[31:0] = 32'hFFFF_FFFF; req_b3[31:0] = 32'd1; req_op3[31:0] = 32'd0;
    @(negedge clk);
    chk("lat3_req_ready", 32'(req_ready3), 32'd1);
    @(posedge clk);
    #1 req_valid3 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lat3_rsp_valid_early", 32'(rsp_valid3), 32'd0);
      chk("lat3_alu_a_held", alu_a3, 32'hFFFF_FFFF);
      chk("lat3_busy", 32'(busy3), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("lat3_rsp_valid", 32'(rsp_valid3), 32'd1);
    chk("lat3_rsp_result", rsp_result3, 32'd0);
    rsp_ready3 = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("lat3_idle", 32'(busy3), 32'd0);
    rsp_ready3 = 2'b00;
    @(posedge clk);
    #1;

    // Directed single operations from a table.
    gen_rate = 0; rdy_rate = 100;
    foreach (vecs[v]) begin
      rsp_log.delete();
      issue(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
      run_until_idle(20);
      if (rsp_log.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d: no response seen, expected result %h", v, vecs[v].res);
      end else begin
        chk($sformatf("vec%0d_result", v), rsp_log[$], vecs[v].res);
      end
    end

    // Round-robin from reset with all four requesting continuously.
    do_reset("rr_rst");
    act_grants.delete();
    rr_mode = 1; gen_rate = 100; rdy_rate = 100;
    for (int i = 0; i < N; i++) issue(i, i, i, 0);
    repeat (16) step();
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_grant%0d", k), (k < act_grants.size()) ? act_grants[k] : -1, exp_order[k]);
    rr_mode = 0; gen_rate = 0;
    run_until_idle(50);

    // Backpressure: owner 1 stalls five cycles while requester 2 waits.
    do_reset("bp_rst");
    rdy_rate = 0;
    issue(1, 32'd100, 32'd23, 32'd1);
    issue(2, 32'd7, 32'd8, 32'd0);
    repeat (2) step();
    repeat (5) step();
    chk("bp_pending2", 32'(pend[2]), 32'd1);
    rdy_rate = 100;
    run_until_idle(20);

    // Reset mid-EXEC: afterwards arbitration restarts from index 0.
    issue(1, 32'd1, 32'd2, 32'd0);
    step();
    issue(0, 32'd9, 32'd4, 32'd1);
    issue(3, 32'd6, 32'd6, 32'd2);
    do_reset("exec_rst");
    act_grants.delete();
    run_until_idle(30);
    chk("exec_rst_first_grant", (act_grants.size() > 0) ? act_grants[0] : -1, 32'd0);

    // Reset mid-RESP: the stalled response is discarded.
    rdy_rate = 0;
    issue(2, 32'd50, 32'd60, 32'd0);
    repeat (2) step();
    do_reset("resp_rst");
    rdy_rate = 100;
    repeat (4) step();

    // Randomized traffic against the model, then drain.
    gen_rate = 30; rdy_rate = 60;
    repeat (2000) step();
    gen_rate = 0; rdy_rate = 100;
    run_until_idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational/fixed-latency 32-bit ALU (operand ports A, B, Op; output Result) among NUM_REQ requesters. Round-robin arbitration, operands registered into the ALU, ALU result captured after ALU_LAT cycles and returned to the granted requester over a valid/ready response handshake. Sits between the requesting units and the single ALU instance; one operation is in flight at a time.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 32: operand/op/result width
- ALU_LAT, 1: ALU cycles from operands stable to Result valid (1..15)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, same packing
- req_op  in  NUM_REQ*DATA_W  opcode, same packing
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_op  out  DATA_W  to ALU Op
- alu_result  in  DATA_W  from ALU Result
- rsp_valid  out  NUM_REQ  one-hot response valid for owning requester
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_result  out  DATA_W  captured ALU result
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant = first i with req_valid[i], searching from rr_ptr upward, wrapping mod NUM_REQ. req_ready[grant] high combinationally in IDLE only. On handshake: latch req_a/b/op[grant] into op registers, owner <= grant, rr_ptr <= (grant+1) mod NUM_REQ, lat_cnt <= ALU_LAT-1, go EXEC. No valid requests: stay IDLE, rr_ptr unchanged.
- alu_a/alu_b/alu_op always driven from op registers (no combinational path from req_* to ALU); they hold their value outside EXEC.
- EXEC: if lat_cnt==0, rsp_result <= alu_result, go RESP; else lat_cnt decrements.
- RESP: rsp_valid[owner] high, rsp_result stable. On rsp_ready[owner] go IDLE. rsp_ready of other bits ignored.
- req_ready all-zero in EXEC and RESP; requests held by requesters until accepted (no drop).
- Opcode passed through unmodified (all DATA_W bits); arbiter does not decode it.
- Reset (any time, including mid-EXEC/RESP): state IDLE, rr_ptr 0, owner 0, lat_cnt 0, op registers 0, rsp_result 0; in-flight op discarded, no response produced.

## Timing
- Reset values: req_ready 0 (then combinational from req_valid), rsp_valid 0, rsp_result 0, alu_a/alu_b/alu_op 0, busy 0.
- Accept at edge T0 -> alu_* show operands from T0 -> result captured at edge T0+ALU_LAT -> rsp_valid high from T0+ALU_LAT.
- ALU_LAT=1: request-to-response 1 cycle after accept; new accept no earlier than the cycle after the response handshake (min 3 cycles/op at zero rsp stall).
- Response held indefinitely while rsp_ready[owner] low; rsp_result must not change.
- Simultaneous requests: exactly one granted per IDLE cycle; every continuously-valid requester served within NUM_REQ operations.
- Requester i may re-request in the cycle its response completes; it is then lowest priority.

## Test plan
- Single op, ALU_LAT=1, bench ALU model (Op 0 ADD, 1 SUB, 2 AND): req0 A=10 B=5 Op=2 -> alu_a=10/alu_op=2 one cycle after accept, rsp_valid[0] next cycle, rsp_result=0 (10&5); req0 A=15 B=10 Op=1 -> rsp_result=5.
- Round-robin: all four request continuously from reset with A=i -> grant order 0,1,2,3,0; each rsp_valid one-hot on correct bit, rsp_result matches owner's operands.
- Backpressure: rsp_ready[1] low 5 cycles while req2 valid -> rsp_valid[1] and rsp_result stable 5 cycles, req_ready[2] stays 0 until after response handshake.
- ALU_LAT=3: single ADD A=0xFFFFFFFF B=1 -> result 0 (wrap) captured exactly 3 cycles after accept; alu_a held throughout.
- Reset mid-EXEC and mid-RESP: rst_n low async -> rsp_valid, busy, alu_* go 0 immediately; after release first grant goes to lowest valid index from 0; no stale response.
